// File: rtl/bin2bcd_arb_seq.sv
// Two-requester 8-bit binary to 3-digit BCD converter sharing one sequential double-dabble engine.
// Define BIN2BCD_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module bin2bcd_arb_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_id,
  output logic [3:0] out_hundreds,
  output logic [3:0] out_tens,
  output logic [3:0] out_ones,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic        prio0;
  logic        grant0, grant1;
  logic [19:0] adj;

`ifdef BIN2BCD_ARB_RR_EN
  logic last_q, last_d;

  // Requester 0 wins a tie only when requester 1 was served by the last accept.
  assign prio0 = last_q;
`else
  assign prio0 = 1'b1;
`endif

  function automatic logic [3:0] dab_adjust(input logic [3:0] nib);
    return (nib > 4'd4) ? nib + 4'd3 : nib;
  endfunction

  assign grant0 = req0_valid && (!req1_valid || prio0);
  assign grant1 = req1_valid && !grant0;

  assign adj = {dab_adjust(acc_q[19:16]), dab_adjust(acc_q[15:12]),
                dab_adjust(acc_q[11:8]), acc_q[7:0]};

  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
`ifdef BIN2BCD_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          acc_d   = {12'b0, grant1 ? req1_data : req0_data};
          cnt_d   = 3'd0;
          id_d    = grant1;
          state_d = SHIFT;
`ifdef BIN2BCD_ARB_RR_EN
          last_d  = grant1;
`endif
        end
      end
      SHIFT: begin
        acc_d = adj << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 20'd0;
      cnt_q   <= 3'd0;
      id_q    <= 1'b0;
`ifdef BIN2BCD_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
`ifdef BIN2BCD_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Ready is gated with rst so no handshake is seen while reset is held.
  assign req0_ready   = (state_q == IDLE) && grant0 && !rst;
  assign req1_ready   = (state_q == IDLE) && grant1 && !rst;
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign out_id       = id_q;
  assign out_hundreds = acc_q[19:16];
  assign out_tens     = acc_q[15:12];
  assign out_ones     = acc_q[11:8];

endmodule

// File: tb/tb_bin2bcd_arb_seq.sv
// Directed self-checking bench for bin2bcd_arb_seq; expected ids follow BIN2BCD_ARB_RR_EN.
module tb_bin2bcd_arb_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       out_valid, out_ready, out_id, busy;
  logic [3:0] out_hundreds, out_tens, out_ones;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bin2bcd_arb_seq dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_id      (out_id),
    .out_hundreds(out_hundreds),
    .out_tens    (out_tens),
    .out_ones    (out_ones),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] digits();
    return {out_hundreds, out_tens, out_ones};
  endfunction

  // Single conversion: accept, 8 shift cycles, result on the 9th cycle, handshake, back to IDLE.
  task automatic run_one(input logic idx, input logic [7:0] d, input logic [11:0] exp);
    logic bad;
    @(negedge clk);
    if (idx) begin req1_valid = 1'b1; req1_data = d; end
    else     begin req0_valid = 1'b1; req0_data = d; end
    #1;
    check("accept_ready", idx ? req1_ready : req0_ready, 1);
    check("accept_other_ready", idx ? req0_ready : req1_ready, 0);
    @(posedge clk);
    #1;
    if (idx) req1_data = ~d; else req0_data = ~d;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid || !busy || req0_ready || req1_ready) bad = 1'b1;
    end
    check("shift_phase", bad, 0);
    @(negedge clk);
    check("done_no_ready", req0_ready | req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("latency_out_valid", out_valid, 1);
    check("digits", digits(), exp);
    check("out_id", out_id, idx);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("back_to_idle", {busy, out_valid}, 0);
  endtask

  initial begin
    logic        bad;
    int          got;
    int          n_exp;
    logic        exp_id  [4];
    logic [11:0] exp_dig [4];

    rst        = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 8'd17;
    req1_valid = 1'b0;
    req1_data  = 8'd0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready0", req0_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_digits", digits(), 12'h000);
    check("rst_out_id", out_id, 0);
    req0_valid = 1'b0;
    rst        = 1'b0;

    run_one(1'b0, 8'd255, 12'h255);
    run_one(1'b0, 8'd0,   12'h000);
    run_one(1'b1, 8'd100, 12'h100);

    // Both requesters valid continuously with the consumer always ready.
`ifdef BIN2BCD_ARB_RR_EN
    n_exp = 4;
    exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_dig = '{12'h099, 12'h007, 12'h099, 12'h007};
`else
    n_exp = 3;
    exp_id  = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_dig = '{12'h099, 12'h099, 12'h099, 12'h099};
`endif
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'd99;
    req1_valid = 1'b1; req1_data = 8'd7;
    out_ready  = 1'b1;
    got = 0;
    bad = 1'b0;
    for (int c = 0; c < 60 && got < n_exp; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) bad = 1'b1;
      if (out_valid) begin
        check("arb_id", out_id, exp_id[got]);
        check("arb_digits", digits(), exp_dig[got]);
        got++;
      end
    end
    check("arb_result_count", got, n_exp);
    check("arb_ready_exclusive", bad, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("arb_idle", busy, 0);

    // 42 held in DONE while the consumer stalls and both requesters keep asking.
    req0_valid = 1'b1;
    req0_data  = 8'd42;
    #1;
    check("stall_accept", req0_ready, 1);
    @(posedge clk);
    #1;
    req0_data  = 8'd200;
    req1_valid = 1'b1;
    req1_data  = 8'd9;
    repeat (8) @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid || digits() != 12'h042 || out_id || req0_ready || req1_ready) bad = 1'b1;
    end
    check("stall_hold", bad, 0);
    @(negedge clk);
    check("stall_still_valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("stall_release_idle", {busy, out_valid}, 0);

    // Reset during the 4th shift cycle aborts the conversion.
    req1_valid = 1'b1;
    req1_data  = 8'd200;
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_digits", digits(), 12'h000);
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid || busy) bad = 1'b1;
    end
    check("abort_no_result", bad, 0);
    run_one(1'b0, 8'd137, 12'h137);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_arb_seq.md
BIN2BCD_ARB_SEQ -- requirements
Module: bin2bcd_arb_seq

Interface
REQ-001 Parameters: none; data width fixed at 8 bits, BCD output fixed at 3 digits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 holds an 8-bit binary operand.
REQ-005 req0_data  input  8  requester 0 operand; stable while req0_valid high.
REQ-006 req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-007 req1_valid / req1_data / req1_ready  same as REQ-004..006 for requester 1.
REQ-008 out_valid  output  1  result registers hold a finished conversion.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_id  output  1  requester index that owns the current result.
REQ-011 out_hundreds / out_tens / out_ones  output  4 each  BCD digits of the result.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states IDLE, SHIFT, DONE; the block shares one sequential double-dabble engine between two requesters.
REQ-014 IDLE: if any reqN_valid, grant one requester per REQ-021, drive its reqN_ready high combinationally that cycle, and load acc[19:0] = {12'b0, data}, iteration count = 0, out_id = granted index; next state SHIFT.
REQ-015 reqN_ready SHALL be high only in IDLE and only for the granted requester; never both in the same cycle.
REQ-016 SHIFT: each cycle, for each BCD nibble acc[11:8], acc[15:12], acc[19:16], add 3 if its value > 4, then shift acc left by 1 with 0 inserted; exactly one iteration per cycle.
REQ-017 SHIFT lasts exactly 8 cycles; after the 8th iteration go to DONE.
REQ-018 Latency: accept in cycle T, out_valid high from cycle T+9.
REQ-019 DONE: out_valid high; out_hundreds = acc[19:16], out_tens = acc[15:12], out_ones = acc[11:8], held stable with out_id until out_valid && out_ready; then go to IDLE.
REQ-020 No new operand is accepted in DONE, including the out handshake cycle; minimum spacing between accepts is 10 cycles.
REQ-021 Arbitration applies only in IDLE: single valid requester is granted; simultaneous valids resolved per Configuration.
REQ-022 Results correct for all inputs 0..255; max output 2/5/5; no overflow of any nibble.
REQ-023 reqN_valid changes outside IDLE have no effect on the conversion in flight.

Reset
REQ-024 On rst high at a clock edge: state IDLE, acc = 0, count = 0, out_id = 0, arbitration pointer = "last served 1", out_valid = 0, busy = 0, all reqN_ready = 0 during rst.
REQ-025 rst mid-SHIFT or in DONE aborts the conversion; no result is presented afterward.
REQ-026 Result digits read 0/0/0 after reset until the next DONE.

Configuration
REQ-027 Macro BIN2BCD_ARB_RR_EN selects arbitration for simultaneous valids.
REQ-028 Defined: round-robin; grant the requester not served by the last accept; pointer updates on each accept.
REQ-029 Undefined: fixed priority, requester 0 always wins; pointer logic absent.

Verification
REQ-030 req0 = 8'd255 alone -> req0_ready 1 cycle, out_valid 9 cycles later, digits 2/5/5, out_id 0.
REQ-031 req0 = 8'd0, then req1 = 8'd100 -> results 0/0/0 id 0, then 1/0/0 id 1.
REQ-032 Both valid continuously, req0 = 8'd99, req1 = 8'd7, out_ready tied 1 -> with macro: ids 0,1,0,1 (0/9/9, 0/0/7 alternating); without macro: ids 0,0,0.
REQ-033 8'd42 accepted, out_ready low 5 cycles in DONE -> digits 0/4/2 and out_id stable, out_valid held, reqN_ready low throughout; IDLE the cycle after out_ready rises.
REQ-034 rst pulsed at 4th SHIFT cycle -> next cycle out_valid 0, busy 0; no result emitted; next operand converts correctly.
